// File: rtl/ddr4_act_scheduler.sv
// DDR4 activate scheduler: bank-group-interleaved round-robin ACT issue under tRRD_S/tRRD_L/tFAW.
// Latency: an eligible request in cycle N drives its ACT on the bus in cycle N+1, for one cycle.
// Backpressure: a request is held by its requester until its req_ready pulse; open banks wait for bank_close.
// Ports: ck_t/reset (sync, active-high); req_valid/req_row per-bank requests; req_ready one-hot grant;
//        bank_close precharge notify; bank_open per-bank state; cs_n/act_n/A/bg/ba registered ACT command bus.
module ddr4_act_scheduler #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int TRRD_S    = 4,
  parameter int TRRD_L    = 6,
  parameter int TFAW      = 20,
  localparam int BANKGROUPS = 2**BGWIDTH,
  localparam int NBANKS     = BANKGROUPS * (2**BAWIDTH)
) (
  input  logic                        ck_t,
  input  logic                        reset,
  input  logic [NBANKS-1:0]           req_valid,
  input  logic [NBANKS*ADDRWIDTH-1:0] req_row,
  output logic [NBANKS-1:0]           req_ready,
  input  logic [NBANKS-1:0]           bank_close,
  output logic [NBANKS-1:0]           bank_open,
  output logic                        cs_n,
  output logic                        act_n,
  output logic [ADDRWIDTH-1:0]        A,
  output logic [BGWIDTH-1:0]          bg,
  output logic [BAWIDTH-1:0]          ba
);

  localparam int PW = BGWIDTH + BAWIDTH;
  localparam int RW = $clog2(TRRD_L + 1);
  localparam int FW = $clog2(TFAW + 1);

  logic [RW-1:0]        rrd_s_q, rrd_s_d;
  logic [RW-1:0]        rrd_l_q [BANKGROUPS];
  logic [RW-1:0]        rrd_l_d [BANKGROUPS];
  logic [FW-1:0]        faw_q   [4];
  logic [FW-1:0]        faw_d   [4];
  logic [1:0]           faw_wp_q, faw_wp_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 cs_n_q, cs_n_d, act_n_q, act_n_d;
  logic [ADDRWIDTH-1:0] a_q, a_d;
  logic [BGWIDTH-1:0]   bg_q, bg_d;
  logic [BAWIDTH-1:0]   ba_q, ba_d;
  logic [NBANKS-1:0]    req_ready_q, req_ready_d;
  logic [NBANKS-1:0]    bank_open_q, bank_open_d;

  logic [ADDRWIDTH-1:0] row_arr [NBANKS];
  logic                 slot_free;
  logic [PW-1:0]        scan_pos;
  logic [BGWIDTH-1:0]   scan_bg;
  logic [BAWIDTH-1:0]   scan_ba;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_pos;
  logic [BGWIDTH-1:0]   gnt_bg;
  logic [BAWIDTH-1:0]   gnt_ba;

  for (genvar g = 0; g < NBANKS; g++) begin : g_row
    assign row_arr[g] = req_row[g*ADDRWIDTH +: ADDRWIDTH];
  end

  // tRRD_S and the oldest tFAW slot gate every bank alike, so test them once.
  assign slot_free = (rrd_s_q == '0) && (faw_q[faw_wp_q] == '0);

  // Scan positions from rr_ptr. The low position bits select the bank group, so
  // adjacent positions hop groups and back-to-back grants mostly hit tRRD_S.
  always_comb begin
    scan_pos = '0;
    scan_bg  = '0;
    scan_ba  = '0;
    gnt_vld  = 1'b0;
    gnt_pos  = '0;
    gnt_bg   = '0;
    gnt_ba   = '0;
    for (int o = 0; o < NBANKS; o++) begin
      scan_pos = rr_ptr_q + PW'(o);
      scan_bg  = scan_pos[BGWIDTH-1:0];
      scan_ba  = scan_pos[PW-1:BGWIDTH];
      if (!gnt_vld && slot_free && req_valid[{scan_bg, scan_ba}] &&
          !bank_open_q[{scan_bg, scan_ba}] && rrd_l_q[scan_bg] == '0) begin
        gnt_vld = 1'b1;
        gnt_pos = scan_pos;
        gnt_bg  = scan_bg;
        gnt_ba  = scan_ba;
      end
    end
  end

  always_comb begin
    rrd_s_d = (rrd_s_q != '0) ? rrd_s_q - RW'(1) : '0;
    for (int g = 0; g < BANKGROUPS; g++) begin
      rrd_l_d[g] = (rrd_l_q[g] != '0) ? rrd_l_q[g] - RW'(1) : '0;
    end
    for (int f = 0; f < 4; f++) begin
      faw_d[f] = (faw_q[f] != '0) ? faw_q[f] - FW'(1) : '0;
    end
    faw_wp_d    = faw_wp_q;
    rr_ptr_d    = rr_ptr_q;
    cs_n_d      = 1'b1;
    act_n_d     = 1'b1;
    a_d         = '0;
    bg_d        = '0;
    ba_d        = '0;
    req_ready_d = '0;
    bank_open_d = bank_open_q & ~bank_close;
    if (gnt_vld) begin
      cs_n_d           = 1'b0;
      act_n_d          = 1'b0;
      a_d              = row_arr[{gnt_bg, gnt_ba}];
      bg_d             = gnt_bg;
      ba_d             = gnt_ba;
      req_ready_d      = NBANKS'(1) << {gnt_bg, gnt_ba};
      // A close arriving on the grant edge is stale: the new row wins.
      bank_open_d      = bank_open_d | req_ready_d;
      rrd_s_d          = RW'(TRRD_S - 1);
      rrd_l_d[gnt_bg]  = RW'(TRRD_L - 1);
      faw_d[faw_wp_q]  = FW'(TFAW - 1);
      faw_wp_d         = faw_wp_q + 2'd1;
      rr_ptr_d         = gnt_pos + PW'(1);
    end
  end

  always_ff @(posedge ck_t) begin
    if (reset) begin
      rrd_s_q     <= '0;
      for (int g = 0; g < BANKGROUPS; g++) rrd_l_q[g] <= '0;
      for (int f = 0; f < 4; f++) faw_q[f] <= '0;
      faw_wp_q    <= '0;
      rr_ptr_q    <= '0;
      cs_n_q      <= 1'b1;
      act_n_q     <= 1'b1;
      a_q         <= '0;
      bg_q        <= '0;
      ba_q        <= '0;
      req_ready_q <= '0;
      bank_open_q <= '0;
    end else begin
      rrd_s_q     <= rrd_s_d;
      for (int g = 0; g < BANKGROUPS; g++) rrd_l_q[g] <= rrd_l_d[g];
      for (int f = 0; f < 4; f++) faw_q[f] <= faw_d[f];
      faw_wp_q    <= faw_wp_d;
      rr_ptr_q    <= rr_ptr_d;
      cs_n_q      <= cs_n_d;
      act_n_q     <= act_n_d;
      a_q         <= a_d;
      bg_q        <= bg_d;
      ba_q        <= ba_d;
      req_ready_q <= req_ready_d;
      bank_open_q <= bank_open_d;
    end
  end

  assign cs_n      = cs_n_q;
  assign act_n     = act_n_q;
  assign A         = a_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign req_ready = req_ready_q;
  assign bank_open = bank_open_q;

endmodule

// File: tb/tb_ddr4_act_scheduler.sv
// Bench for ddr4_act_scheduler at default parameters.
// Expected ACTs are queued as stimulus is applied; a negedge monitor pops and compares them.
// Each scenario task also checks bank state and that its expected ACTs were all consumed.
module tb_ddr4_act_scheduler;
  localparam int NB = 16;
  localparam int AW = 17;

  logic            ck_t = 1'b0;
  logic            reset;
  logic [NB-1:0]   req_valid;
  logic [NB*AW-1:0] req_row;
  logic [NB-1:0]   req_ready;
  logic [NB-1:0]   bank_close;
  logic [NB-1:0]   bank_open;
  logic            cs_n, act_n;
  logic [AW-1:0]   A;
  logic [1:0]      bg, ba;

  ddr4_act_scheduler dut (
    .ck_t(ck_t), .reset(reset), .req_valid(req_valid), .req_row(req_row),
    .req_ready(req_ready), .bank_close(bank_close), .bank_open(bank_open),
    .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba)
  );

  always #5 ck_t = ~ck_t;

  int cyc = 0;
  always @(posedge ck_t) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    int bg;
    int ba;
    int row;
  } act_t;
  act_t exp_q[$];
  act_t mon_e;
  logic [NB-1:0] exp_ready;

  task automatic step();
    @(posedge ck_t);
    #1;
  endtask

  task automatic set_rows();
    for (int i = 0; i < NB; i++) req_row[i*AW +: AW] = AW'(i + 1);
  endtask

  // Row programmed for bank (b,a) is its bank index + 1.
  task automatic push_act(input int c, input int b, input int a);
    act_t e;
    e.cyc = c; e.bg = b; e.ba = a; e.row = b * 4 + a + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    reset      = 1'b1;
    req_valid  = '0;
    bank_close = '0;
    step();
    step();
    reset  = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: every bus cycle is either an expected ACT or idle.
  always @(negedge ck_t) begin
    if (mon_en) begin
      checks++;
      if (cs_n === 1'b0 || act_n === 1'b0 || req_ready !== '0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_act: cycle %0d cs_n=%b act_n=%b bg=%0d ba=%0d A=%0d ready=%h, required no ACT",
                   cyc, cs_n, act_n, bg, ba, A, req_ready);
        end else begin
          mon_e     = exp_q.pop_front();
          exp_ready = NB'(1) << (mon_e.bg * 4 + mon_e.ba);
          if (cyc !== mon_e.cyc || cs_n !== 1'b0 || act_n !== 1'b0 || bg !== 2'(mon_e.bg) ||
              ba !== 2'(mon_e.ba) || A !== AW'(mon_e.row) || req_ready !== exp_ready) begin
            errors++;
            $display("FAIL act: got cycle %0d cs_n=%b act_n=%b bg=%0d ba=%0d A=%0d ready=%h, required cycle %0d bg=%0d ba=%0d A=%0d ready=%h",
                     cyc, cs_n, act_n, bg, ba, A, req_ready, mon_e.cyc, mon_e.bg, mon_e.ba, mon_e.row, exp_ready);
          end
        end
      end else if (cs_n !== 1'b1 || act_n !== 1'b1 || A !== '0 || bg !== '0 || ba !== '0) begin
        errors++;
        $display("FAIL idle_bus: cycle %0d cs_n=%b act_n=%b A=%0d bg=%0d ba=%0d, required 1 1 0 0 0",
                 cyc, cs_n, act_n, A, bg, ba);
      end
    end
  end

  task automatic test_reset();
    mon_en     = 1'b0;
    set_rows();
    req_valid  = '1;
    bank_close = '0;
    reset      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cs_n !== 1'b1 || act_n !== 1'b1 || A !== '0 || bg !== '0 || ba !== '0 ||
          req_ready !== '0 || bank_open !== '0) begin
        errors++;
        $display("FAIL reset_state: cs_n=%b act_n=%b A=%0d bg=%0d ba=%0d ready=%h open=%h, required idle/0",
                 cs_n, act_n, A, bg, ba, req_ready, bank_open);
      end
    end
    reset = 1'b0;
    push_act(cyc + 1, 0, 0);
    mon_en = 1'b1;
    step();
    req_valid = '0;
    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_first_act: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_interleave();
    int t0;
    do_reset();
    set_rows();
    t0 = cyc;
    req_valid = '1;
    for (int g = 0; g < NB; g++) push_act(t0 + 1 + (g / 4) * 20 + (g % 4) * 4, g % 4, g / 4);
    repeat (80) step();
    checks++;
    if (bank_open !== 16'hFFFF) begin
      errors++;
      $display("FAIL interleave_open: bank_open=%h, required ffff", bank_open);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL interleave_drain: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
    req_valid = '0;
  endtask

  task automatic test_same_group();
    int t0;
    do_reset();
    set_rows();
    t0 = cyc;
    req_valid = 16'h000F;
    for (int k = 0; k < 4; k++) push_act(t0 + 1 + k * 6, 0, k);
    repeat (25) step();
    checks++;
    if (bank_open !== 16'h000F) begin
      errors++;
      $display("FAIL same_group_open: bank_open=%h, required 000f", bank_open);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL same_group_drain: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
    req_valid = '0;
  endtask

  task automatic test_open_hold();
    int p;
    do_reset();
    set_rows();
    req_valid = 16'h0001;
    push_act(cyc + 1, 0, 0);
    step();
    checks++;
    if (bank_open !== 16'h0001) begin
      errors++;
      $display("FAIL open_after_grant: bank_open=%h, required 0001", bank_open);
    end
    repeat (30) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL open_first_act: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
    // Close held over two edges: the second coincides with the re-grant and must lose.
    p = cyc;
    bank_close = 16'h0001;
    push_act(p + 2, 0, 0);
    step();
    step();
    bank_close = '0;
    req_valid  = '0;
    checks++;
    if (bank_open !== 16'h0001) begin
      errors++;
      $display("FAIL close_vs_grant: bank_open=%h, required 0001", bank_open);
    end
    repeat (8) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL open_reopen_act: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset();
    set_rows();
    t0 = cyc;
    req_valid = '1;
    push_act(t0 + 1, 0, 0);
    push_act(t0 + 5, 1, 0);
    push_act(t0 + 8, 0, 0);
    repeat (6) step();
    reset = 1'b1;
    step();
    checks++;
    if (bank_open !== '0 || cs_n !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: bank_open=%h cs_n=%b ready=%h, required 0000 1 0000",
               bank_open, cs_n, req_ready);
    end
    reset = 1'b0;
    step();
    req_valid = '0;
    repeat (5) step();
    checks++;
    if (bank_open !== 16'h0001) begin
      errors++;
      $display("FAIL reset_mid_open: bank_open=%h, required 0001", bank_open);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_fairness();
    int t0;
    do_reset();
    set_rows();
    t0 = cyc;
    req_valid = 16'h0011;
    for (int g = 0; g < 8; g++) push_act(t0 + 1 + (g / 4) * 20 + (g % 4) * 4, g % 2, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      bank_close = req_ready;
      if (cyc == t0 + 33) req_valid = '0;
    end
    bank_close = '0;
    step();
    checks++;
    if (bank_open !== '0) begin
      errors++;
      $display("FAIL fairness_open: bank_open=%h, required 0000", bank_open);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fairness_drain: %0d ACTs missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_row    = '0;
    bank_close = '0;
    test_reset();
    test_interleave();
    test_same_group();
    test_open_hold();
    test_reset_mid();
    test_fairness();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
